// File: rtl/mmio_fifo_pkg.sv
// rtl/mmio_fifo_pkg.sv - register map, bit positions and status layout for mmio_fifo_ctrl
package mmio_fifo_pkg;

  localparam logic [15:0] DATA_OFS   = 16'd0;
  localparam logic [15:0] STATUS_OFS = 16'd2;
  localparam logic [15:0] CTRL_OFS   = 16'd4;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_UDF       = 3;
  localparam int ST_COUNT_LSB = 16;

  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLEAR = 1;

  typedef struct packed {
    logic [31:0] rsvd_hi;
    logic [15:0] count;
    logic [11:0] rsvd_lo;
    logic        udf;
    logic        ovf;
    logic        full;
    logic        empty;
  } t_fifo_status;

endpackage

// File: rtl/sync_fifo_buf.sv
// rtl/sync_fifo_buf.sv - unguarded FWFT storage with wrapping pointers and occupancy count
module sync_fifo_buf #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; its contents only matter once count says so.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/mmio_fifo_ctrl.sv
// rtl/mmio_fifo_ctrl.sv - MMIO register window (DATA/STATUS/CTRL) around a small FIFO
import mmio_fifo_pkg::*;

module mmio_fifo_ctrl #(
  parameter int          DEPTH     = 8,
  parameter int          WIDTH     = 64,
  parameter logic [15:0] BASE_ADDR = 16'h0020
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mmio_wr_valid,
  input  logic                       mmio_rd_valid,
  input  logic [15:0]                mmio_addr,
  input  logic [8:0]                 mmio_tid,
  input  logic [63:0]                mmio_wdata,
  output logic                       rd_rsp_valid,
  output logic [8:0]                 rd_rsp_tid,
  output logic [63:0]                rd_rsp_data,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  logic hit_data, hit_status, hit_ctrl;
  logic wr_data, rd_data, rd_any, wr_ctrl;
  logic push, pop, flush, flag_clr, ovf_set, udf_set;
  logic full, empty, ovf, udf;
  logic [WIDTH-1:0] dout;
  logic [63:0]      rsp_data_nxt;
  t_fifo_status     status;

  assign hit_data   = (mmio_addr == BASE_ADDR + DATA_OFS);
  assign hit_status = (mmio_addr == BASE_ADDR + STATUS_OFS);
  assign hit_ctrl   = (mmio_addr == BASE_ADDR + CTRL_OFS);

  assign wr_data = mmio_wr_valid && hit_data;
  assign wr_ctrl = mmio_wr_valid && hit_ctrl;
  assign rd_data = mmio_rd_valid && hit_data;
  assign rd_any  = mmio_rd_valid && (hit_data || hit_status || hit_ctrl);

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign pop      = rd_data && !empty;
  assign push     = wr_data && (!full || pop);
  assign ovf_set  = wr_data && !push;
  assign udf_set  = rd_data && empty;
  assign flush    = wr_ctrl && mmio_wdata[CTRL_FLUSH];
  assign flag_clr = wr_ctrl && mmio_wdata[CTRL_CLEAR];

  sync_fifo_buf #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (mmio_wdata[WIDTH-1:0]),
    .dout  (dout),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf_set || (ovf && !flag_clr);
      udf <= udf_set || (udf && !flag_clr);
    end
  end

  always_comb begin
    status       = '0;
    status.empty = empty;
    status.full  = full;
    status.ovf   = ovf;
    status.udf   = udf;
    status.count = 16'(fifo_count);
  end

  // STATUS reads see pre-edge state; CTRL reads and DATA underflow return zero.
  always_comb begin
    rsp_data_nxt = '0;
    if (pop)
      rsp_data_nxt = 64'(dout);
    else if (hit_status)
      rsp_data_nxt = status;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_tid   <= '0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= rd_any;
      if (rd_any) begin
        rd_rsp_tid  <= mmio_tid;
        rd_rsp_data <= rsp_data_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mmio_fifo_ctrl.sv
// tb/tb_mmio_fifo_ctrl.sv - table-driven self-checking bench for mmio_fifo_ctrl
module tb_mmio_fifo_ctrl;

  localparam logic [15:0] A_DATA = 16'h0020;
  localparam logic [15:0] A_STAT = 16'h0022;
  localparam logic [15:0] A_CTRL = 16'h0024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mmio_wr_valid = 1'b0;
  logic        mmio_rd_valid = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [8:0]  mmio_tid = '0;
  logic [63:0] mmio_wdata = '0;
  logic        rd_rsp_valid;
  logic [8:0]  rd_rsp_tid;
  logic [63:0] rd_rsp_data;
  logic [3:0]  fifo_count;

  int passed = 0;
  int total  = 0;

  mmio_fifo_ctrl #(.DEPTH(8), .WIDTH(64), .BASE_ADDR(16'h0020)) dut (
    .clk           (clk),
    .rst           (rst),
    .mmio_wr_valid (mmio_wr_valid),
    .mmio_rd_valid (mmio_rd_valid),
    .mmio_addr     (mmio_addr),
    .mmio_tid      (mmio_tid),
    .mmio_wdata    (mmio_wdata),
    .rd_rsp_valid  (rd_rsp_valid),
    .rd_rsp_tid    (rd_rsp_tid),
    .rd_rsp_data   (rd_rsp_data),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic        exp_rsp;
    logic [63:0] exp_data;
    logic [3:0]  exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic wr, logic rd, logic [15:0] addr, logic [63:0] wdata,
                              logic [63:0] exp_data, int exp_count);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata;
    v.exp_rsp = rd && (addr == A_DATA || addr == A_STAT || addr == A_CTRL);
    v.exp_data = exp_data;
    v.exp_count = 4'(exp_count);
    vecs.push_back(v);
  endfunction

  function automatic void wr_v(logic [15:0] a, logic [63:0] d, int c);
    add(1'b1, 1'b0, a, d, 64'h0, c);
  endfunction

  function automatic void rd_v(logic [15:0] a, logic [63:0] e, int c);
    add(1'b0, 1'b1, a, 64'h0, e, c);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    // Reset then empty-FIFO reads
    rd_v(A_STAT, 64'h1, 0);
    rd_v(A_DATA, 64'h0, 0);
    rd_v(A_STAT, 64'h9, 0);
    wr_v(A_CTRL, 64'h2, 0);
    rd_v(A_STAT, 64'h1, 0);
    // In-order push/pop
    wr_v(A_DATA, 64'hA, 1);
    wr_v(A_DATA, 64'hB, 2);
    wr_v(A_DATA, 64'hC, 3);
    rd_v(A_STAT, 64'h0003_0000, 3);
    rd_v(A_DATA, 64'hA, 2);
    rd_v(A_DATA, 64'hB, 1);
    rd_v(A_DATA, 64'hC, 0);
    rd_v(A_STAT, 64'h1, 0);
    // Outside the window / ignored registers
    rd_v(16'h0021, 64'h0, 0);
    wr_v(16'h0026, 64'h3, 0);
    wr_v(A_STAT, 64'hF, 0);
    rd_v(A_CTRL, 64'h0, 0);
    // Overflow then underflow
    for (int i = 1; i <= 9; i++) wr_v(A_DATA, 64'(i), (i > 8) ? 8 : i);
    rd_v(A_STAT, 64'h0008_0006, 8);
    for (int i = 1; i <= 8; i++) rd_v(A_DATA, 64'(i), 8 - i);
    rd_v(A_DATA, 64'h0, 0);
    rd_v(A_STAT, 64'hD, 0);
    wr_v(A_CTRL, 64'h2, 0);
    // Wrap-around
    for (int i = 0; i < 20; i++) begin
      wr_v(A_DATA, 64'h100 + 64'(i), 1);
      rd_v(A_DATA, 64'h100 + 64'(i), 0);
    end
    // Simultaneous push/pop while full
    for (int i = 1; i <= 8; i++) wr_v(A_DATA, 64'(i), i);
    add(1'b1, 1'b1, A_DATA, 64'h55, 64'h1, 8);
    rd_v(A_STAT, 64'h0008_0002, 8);
    for (int i = 2; i <= 8; i++) rd_v(A_DATA, 64'(i), 9 - i);
    rd_v(A_DATA, 64'h55, 0);
    // Simultaneous push/pop while empty: underflow, no bypass
    add(1'b1, 1'b1, A_DATA, 64'h77, 64'h0, 1);
    rd_v(A_STAT, 64'h0001_0008, 1);
    rd_v(A_DATA, 64'h77, 0);
    wr_v(A_CTRL, 64'h2, 0);
    // Flush + clear with 4 entries and ovf set
    for (int i = 1; i <= 9; i++) wr_v(A_DATA, 64'(i), (i > 8) ? 8 : i);
    for (int i = 1; i <= 4; i++) rd_v(A_DATA, 64'(i), 8 - i);
    rd_v(A_STAT, 64'h0004_0004, 4);
    wr_v(A_CTRL, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    rd_v(A_STAT, 64'h1, 0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_valid", 64'(rd_rsp_valid), 64'h0);
    chk("reset_data", rd_rsp_data, 64'h0);
    chk("reset_tid", 64'(rd_rsp_tid), 64'h0);
    chk("reset_count", 64'(fifo_count), 64'h0);

    foreach (vecs[i]) begin
      mmio_wr_valid = vecs[i].wr;
      mmio_rd_valid = vecs[i].rd;
      mmio_addr     = vecs[i].addr;
      mmio_wdata    = vecs[i].wdata;
      mmio_tid      = 9'(i + 3);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), 64'(rd_rsp_valid), 64'(vecs[i].exp_rsp));
      chk($sformatf("v%0d_count", i), 64'(fifo_count), 64'(vecs[i].exp_count));
      if (vecs[i].exp_rsp) begin
        chk($sformatf("v%0d_data", i), rd_rsp_data, vecs[i].exp_data);
        chk($sformatf("v%0d_tid", i), 64'(rd_rsp_tid), 64'(9'(i + 3)));
      end
    end
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b0;

    // Hold: response fields keep their last value when idle
    @(posedge clk); #1;
    chk("idle_valid", 64'(rd_rsp_valid), 64'h0);
    chk("idle_hold_data", rd_rsp_data, 64'h1);

    // Reset with a read pending mid-cycle
    mmio_wr_valid = 1'b1; mmio_addr = A_DATA; mmio_wdata = 64'hBEEF;
    @(posedge clk); #1;
    mmio_wr_valid = 1'b0;
    mmio_rd_valid = 1'b1; mmio_addr = A_STAT; mmio_tid = 9'h1AB;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_count", 64'(fifo_count), 64'h0);
    chk("async_rst_data", rd_rsp_data, 64'h0);
    @(posedge clk); #1;
    chk("rst_no_pulse", 64'(rd_rsp_valid), 64'h0);
    chk("rst_tid", 64'(rd_rsp_tid), 64'h0);
    mmio_rd_valid = 1'b0;
    rst = 1'b0;
    mmio_rd_valid = 1'b1; mmio_tid = 9'h055;
    @(posedge clk); #1;
    mmio_rd_valid = 1'b0;
    chk("post_rst_valid", 64'(rd_rsp_valid), 64'h1);
    chk("post_rst_status", rd_rsp_data, 64'h1);
    chk("post_rst_tid", 64'(rd_rsp_tid), 64'h055);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mmio_fifo_ctrl.md
# mmio_fifo_ctrl

MMIO-facing controller that owns a small synchronous FIFO and exposes it to the host as a three-register window in the AFU's CCI-P MMIO space. It decodes MMIO writes/reads, converts them into push/pop/flush operations, tracks occupancy and sticky error flags, and generates the registered MMIO read response (data + TID). It sits between the AFU's Rx c0 MMIO decode and the Tx c2 response mux. The top level forwards `rd_rsp_*` only when `rd_rsp_valid` is set.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `WIDTH`, 64: data width; ≤ 64, zero-extended in responses.
- `BASE_ADDR`, 16'h0020: MMIO word address of the DATA register.

- `clk`  in  1  single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `mmio_wr_valid`  in  1  MMIO write strobe (Rx c0 mmioWrValid).
- `mmio_rd_valid`  in  1  MMIO read strobe (Rx c0 mmioRdValid).
- `mmio_addr`  in  16  MMIO word address from the request header.
- `mmio_tid`  in  9  transaction ID of a read request.
- `mmio_wdata`  in  64  write data.
- `rd_rsp_valid`  out  1  one-cycle read-response strobe, set only when the address hits the window.
- `rd_rsp_tid`  out  9  TID echoed from the request.
- `rd_rsp_data`  out  64  response data.
- `fifo_count`  out  $clog2(DEPTH+1)  current occupancy.

## Operation
- Register window (word addresses):
  - DATA = BASE.
  - STATUS = BASE+2.
  - CTRL = BASE+4.
  - Addresses outside the window are ignored, with no response and no state change.
- Write DATA:
  - Not full: push `mmio_wdata[WIDTH-1:0]`.
  - Full: drop the data, set sticky `ovf`, leave pointers unchanged.
- Read DATA:
  - Not empty: respond with the head entry (first-word-fall-through) and pop it.
  - Empty: respond with 0, set sticky `udf`, leave pointers unchanged.
- Read STATUS returns:
  - bit0 `empty`, bit1 `full`, bit2 `ovf`, bit3 `udf`.
  - bits[31:16] `count`.
  - All other bits 0.
- Write STATUS: ignored.
- Write CTRL:
  - bit0 = flush: pointers and count go to 0.
  - bit1 = clear both sticky flags.
  - Both bits may be set together. Other bits are ignored.
- Read CTRL: returns 0.
- Simultaneous `mmio_wr_valid` and `mmio_rd_valid`: both are processed in the same cycle.
  - Push and pop in the same cycle: count unchanged. When full, both succeed and there is no `ovf`. When empty, the pop underflows and returns 0 (no bypass), and the push succeeds.
  - Read of STATUS with a concurrent write: returns the pre-cycle state.
  - Read of DATA with a concurrent CTRL flush: pops or underflows against pre-flush contents; the flush wins for the final pointer state.
  - Sticky flag set and CTRL clear in the same cycle: set wins.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from `count`, not from pointer equality.

## Timing
- Read response: `rd_rsp_valid` pulses exactly 1 cycle after the accepted `mmio_rd_valid`, with `rd_rsp_tid`/`rd_rsp_data` valid in that same cycle. Back-to-back reads give back-to-back pulses.
- When `rd_rsp_valid` = 0, `rd_rsp_data`/`rd_rsp_tid` hold their last value.
- Push, pop, flush and flag updates take effect at the clock edge of the request. `fifo_count` is registered and reflects them the next cycle.
- Reset (asynchronous, any time, including with a request in flight):
  - `rd_rsp_valid` = 0, `rd_rsp_tid` = 0, `rd_rsp_data` = 0.
  - `fifo_count` = 0, pointers = 0, `ovf` = `udf` = 0, so the FIFO is empty.
  - The in-flight response is discarded.
  - Storage contents are don't-care.
- No stalls: every request is accepted in the cycle it is presented.

## Structure
- Package `mmio_fifo_pkg`:
  - Register offsets (DATA_OFS = 0, STATUS_OFS = 2, CTRL_OFS = 4).
  - STATUS bit positions and CTRL bit positions.
  - A `t_fifo_status` packed struct.
- Sub-module `sync_fifo_buf` (params DEPTH, WIDTH):
  - Storage array, wrap pointers, count, full/empty.
  - Inputs `push`, `pop`, `flush`, `din`; outputs `dout`, `count`, `full`, `empty`.
  - Does not guard illegal operations; the controller masks push-when-full and pop-when-empty.
- `mmio_fifo_ctrl` holds address decode, sticky flags, and the response register.

## Test plan
- Reset, then read STATUS → response next cycle, data = 64'h1 (empty), TID echoed; read DATA → data 0, then STATUS = 64'h9.
- Push 0xA, 0xB, 0xC, then read DATA three times → responses 0xA, 0xB, 0xC in order, each 1 cycle after its request; final STATUS = 64'h1.
- Push DEPTH+1 values 1..9 (DEPTH=8) → STATUS = {count=8, ovf, full} = 64'h0008_0006; pops return 1..8; the ninth pop returns 0 and sets `udf`.
- Wrap-around: 20 interleaved push/pop pairs with values 0x100+i → every pop returns the matching value; count never exceeds 1.
- Full FIFO with simultaneous write DATA 0x55 and read DATA → pop returns the oldest entry, count stays 8, `ovf` stays 0; eight more pops end with 0x55.
- Write CTRL = 3 with the FIFO holding 4 entries and `ovf` set → STATUS = 64'h1. Assert `rst` mid-stream with a read pending → no response pulse, and all outputs are 0.
